rtype_exec_wb: RTL and testbench
================================

Name: rtype_exec_wb

Overview:
- Execute and write-back stage directly downstream of the single-cycle fetch/decode/register-read path.
- Consumes a fetched RV32I R-type instruction and its two register-file read operands (RD1, RD2).
- Computes the ALU result and drives the register-file write port (WR/WD/WE).
- Shifts use an iterative 1-bit-per-cycle shifter, so the stage uses a valid/ready handshake and a small FSM.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHAMT_W, 5, shift-amount width, taken from RD2[SHAMT_W-1:0].

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  INST/RD1/RD2 are valid this cycle.
- IN_READY  output  1  stage can accept; equals (state==IDLE), decoded from registered state.
- INST  input  32  instruction word: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0].
- RD1  input  XLEN  rs1 operand.
- RD2  input  XLEN  rs2 operand.
- WR  output  5  write register index (registered).
- WD  output  XLEN  write data (registered).
- WE  output  1  register-file write enable, one-cycle pulse (registered).
- ILLEGAL  output  1  one-cycle pulse when an accepted instruction is not a legal R-type.

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE; WE=0, WR=0, WD=0, ILLEGAL=0, shift counter=0. IN_READY=1 from the first cycle after reset.
- Reset mid-operation (SHIFT or WB) aborts with no write; the instruction is lost.
- States: IDLE, SHIFT, WB.
- Accept: when IN_VALID && IN_READY at a CLK edge, latch rd=INST[11:7] and decode.
- Legality:
  - opcode must be 0110011.
  - funct7 must be 0000000 for all funct3 values.
  - funct7 may also be 0100000, but only for funct3=000 (sub) and funct3=101 (sra).
  - Anything else: ILLEGAL=1 for the following cycle, no write, remain IDLE.
- Non-shift ops (add, sub, slt, sltu, xor, or, and):
  - Result computed from RD1/RD2 at acceptance and registered into WD; next state is WB.
  - add/sub wrap modulo 2^32.
  - slt compares signed; sltu compares unsigned. Result is 0 or 1, zero-extended.
- Shift ops (sll, srl, sra):
  - Shift amount = RD2[4:0]; latch operand = RD1 and counter = shift amount.
  - Amount 0: go directly to WB with WD=RD1.
  - Otherwise go to SHIFT. Each cycle: shift by 1 (sra replicates bit 31), decrement counter. When the counter reaches 0, go to WB.
- WB (exactly one cycle):
  - WE=1 and WR=rd, unless rd==0, in which case WE stays 0 (x0 is never written).
  - WD holds the result. Return to IDLE.
- Latency: accepted at edge N.
  - Non-shift op: WE high during cycle N+1.
  - Shift by k>0: WE high during cycle N+1+k.
  - Next accept possible at edge N+2 (non-shift) or N+2+k (shift).
- Outputs:
  - IN_READY=0 in SHIFT and WB.
  - INST/RD1/RD2 are ignored outside IDLE.
  - IN_VALID without IN_READY has no effect.
  - WD/WR hold their last values while WE=0.
- Simultaneous events: RST has priority over acceptance and over WB.

Decomposition:
- Shared package holds:
  - opcode constant OP_RTYPE=7'b0110011.
  - funct3 codes F3_ADDSUB=000, F3_SLL=001, F3_SLT=010, F3_SLTU=011, F3_XOR=100, F3_SRL_SRA=101, F3_OR=110, F3_AND=111.
  - funct7 codes F7_BASE=0000000, F7_ALT=0100000.
  - FSM state encoding and ALU-op enumeration.
- One sub-module: rtype_iter_shifter.
  - Holds the operand, counter and direction/arith flags; load/step/done interface.
  - Used by rtype_exec_wb in the SHIFT state.

Test Plan:
- add: RD1=5, RD2=7, rd=3, accept at N -> WE=1, WR=3, WD=12 during N+1 only; IN_READY=1 again at N+2.
- sub: RD1=3, RD2=5, rd=4 -> WD=32'hFFFFFFFE. add with 32'hFFFFFFFF+1 -> WD=0.
- slt/sltu: RD1=32'hFFFFFFFF, RD2=1 -> slt WD=1, sltu WD=0.
- sra: RD1=32'h80000000, RD2=36 (shamt 4), rd=9 -> IN_READY=0 for N+1..N+5, WE at N+5 with WD=32'hF8000000. Same operands with srl -> 32'h08000000. sll with shamt 0 -> WD=RD1 at N+1.
- rd=0 add -> WE never asserts. opcode 0010011 or funct7=0100000 with funct3=111 -> ILLEGAL pulse at N+1, no WE, IN_READY stays 1.
- Reset mid-shift: sll by 20, assert RST at N+3 -> no WE ever, WE=0/WR=0/WD=0 after reset; next add completes normally.

Source files
------------

// File: rtl/rtype_exec_wb_pkg.sv
// Shared constants, types and helper functions for the R-type execute /
// write-back stage and its iterative shifter.
package rtype_exec_wb_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  // Instruction field encodings
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;

  localparam logic [2:0] F3_ADDSUB  = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_WB      = 2'd2;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic    legal;
    logic    is_shift;
    alu_op_e op;
  } decode_t;

  // Classify an instruction word: legality, shift/non-shift, ALU operation.
  function automatic decode_t decode_rtype(input logic [31:0] inst);
    decode_t    d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = inst[31:25];
    f3 = inst[14:12];
    d.legal    = 1'b0;
    d.is_shift = 1'b0;
    d.op       = ALU_ADD;
    if (inst[6:0] == OP_RTYPE) begin
      case (f3)
        F3_ADDSUB: begin
          if (f7 == F7_BASE) begin
            d.legal = 1'b1;
            d.op    = ALU_ADD;
          end else if (f7 == F7_ALT) begin
            d.legal = 1'b1;
            d.op    = ALU_SUB;
          end else begin
            d.legal = 1'b0;
          end
        end
        F3_SRL_SRA: begin
          d.is_shift = 1'b1;
          if (f7 == F7_BASE) begin
            d.legal = 1'b1;
            d.op    = ALU_SRL;
          end else if (f7 == F7_ALT) begin
            d.legal = 1'b1;
            d.op    = ALU_SRA;
          end else begin
            d.legal = 1'b0;
          end
        end
        default: begin
          // Remaining funct3 codes only exist with the base funct7.
          d.legal = (f7 == F7_BASE);
          case (f3)
            F3_SLL: begin
              d.op       = ALU_SLL;
              d.is_shift = 1'b1;
            end
            F3_SLT:  d.op = ALU_SLT;
            F3_SLTU: d.op = ALU_SLTU;
            F3_XOR:  d.op = ALU_XOR;
            F3_OR:   d.op = ALU_OR;
            F3_AND:  d.op = ALU_AND;
            default: d.op = ALU_ADD;
          endcase
        end
      endcase
    end else begin
      d.legal = 1'b0;
    end
    return d;
  endfunction

  // Single-cycle result for every operation that does not use the shifter.
  function automatic logic [XLEN-1:0] alu_result(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rtype_exec_wb_iter_shifter.sv
// Iterative shifter: moves the operand by one bit per step and counts the
// remaining amount down. step_value is the operand after the next step, so
// the owner can capture the final result on the same edge as the last step.
module rtype_iter_shifter
  import rtype_exec_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [XLEN-1:0]    load_value,
  input  logic [SHAMT_W-1:0] load_amount,
  input  logic               load_right,
  input  logic               load_arith,
  output logic [XLEN-1:0]    step_value,
  output logic               last
);

  logic [XLEN-1:0]    value_r;
  logic [SHAMT_W-1:0] count_r;
  logic               right_r;
  logic               arith_r;
  logic               fill_s;

  // One-bit shift of the held operand in the latched direction.
  always_comb begin
    fill_s     = arith_r & value_r[XLEN-1];
    step_value = value_r;
    if (right_r) begin
      step_value = {fill_s, value_r[XLEN-1:1]};
    end else begin
      step_value = {value_r[XLEN-2:0], 1'b0};
    end
  end

  assign last = (count_r == SHAMT_W'(1));

  // Operand/counter register: load new work, or advance one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= {XLEN{1'b0}};
      count_r <= {SHAMT_W{1'b0}};
      right_r <= 1'b0;
      arith_r <= 1'b0;
    end else if (load) begin
      value_r <= load_value;
      count_r <= load_amount;
      right_r <= load_right;
      arith_r <= load_arith;
    end else if (step && (count_r != {SHAMT_W{1'b0}})) begin
      value_r <= step_value;
      count_r <= count_r - SHAMT_W'(1);
    end else begin
      value_r <= value_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/rtype_exec_wb.sv
// Execute and write-back stage for RV32I R-type instructions. Non-shift
// operations finish in one cycle; shifts run through the iterative shifter.
// The register-file write port (WR/WD/WE) and ILLEGAL are registered.
module rtype_exec_wb
  import rtype_exec_wb_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INST,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  output logic [4:0]      WR,
  output logic [XLEN-1:0] WD,
  output logic            WE,
  output logic            ILLEGAL
);

  logic [1:0]         state_r;
  logic [4:0]         rd_r;
  logic [4:0]         wr_r;
  logic [XLEN-1:0]    wd_r;
  logic               we_r;
  logic               illegal_r;

  decode_t            dec_s;
  logic [4:0]         inst_rd_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [1:0]         state_next_s;
  logic               enter_wb_s;
  logic [4:0]         wb_rd_s;
  logic [XLEN-1:0]    wb_data_s;
  logic               illegal_next_s;
  logic               sh_load_s;
  logic               sh_step_s;
  logic               sh_last_s;
  logic [XLEN-1:0]    sh_step_value_s;

  assign dec_s     = decode_rtype(INST);
  assign inst_rd_s = INST[11:7];
  assign shamt_s   = RD2[SHAMT_W-1:0];

  rtype_iter_shifter u_shifter (
    .clk         (CLK),
    .rst         (RST),
    .load        (sh_load_s),
    .step        (sh_step_s),
    .load_value  (RD1),
    .load_amount (shamt_s),
    .load_right  (dec_s.op != ALU_SLL),
    .load_arith  (dec_s.op == ALU_SRA),
    .step_value  (sh_step_value_s),
    .last        (sh_last_s)
  );

  // Next-state logic: acceptance/decode in IDLE, shift stepping, WB exit.
  always_comb begin
    state_next_s   = state_r;
    enter_wb_s     = 1'b0;
    wb_rd_s        = rd_r;
    wb_data_s      = {XLEN{1'b0}};
    illegal_next_s = 1'b0;
    sh_load_s      = 1'b0;
    sh_step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (IN_VALID) begin
          if (!dec_s.legal) begin
            illegal_next_s = 1'b1;
            state_next_s   = ST_IDLE;
          end else if (dec_s.is_shift) begin
            if (shamt_s == {SHAMT_W{1'b0}}) begin
              // Zero shift needs no iteration: result is the operand itself.
              enter_wb_s   = 1'b1;
              wb_rd_s      = inst_rd_s;
              wb_data_s    = RD1;
              state_next_s = ST_WB;
            end else begin
              sh_load_s    = 1'b1;
              state_next_s = ST_SHIFT;
            end
          end else begin
            enter_wb_s   = 1'b1;
            wb_rd_s      = inst_rd_s;
            wb_data_s    = alu_result(dec_s.op, RD1, RD2);
            state_next_s = ST_WB;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_step_s = 1'b1;
        if (sh_last_s) begin
          // Capture the final step's value directly into the write port.
          enter_wb_s   = 1'b1;
          wb_rd_s      = rd_r;
          wb_data_s    = sh_step_value_s;
          state_next_s = ST_WB;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_WB: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, destination latch and registered write-port / illegal outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      rd_r      <= 5'd0;
      wr_r      <= 5'd0;
      wd_r      <= {XLEN{1'b0}};
      we_r      <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      illegal_r <= illegal_next_s;
      we_r      <= enter_wb_s && (wb_rd_s != 5'd0);
      if (sh_load_s) begin
        rd_r <= inst_rd_s;
      end else begin
        rd_r <= rd_r;
      end
      // x0 is never written, and WR/WD only move together with a write.
      if (enter_wb_s && (wb_rd_s != 5'd0)) begin
        wr_r <= wb_rd_s;
        wd_r <= wb_data_s;
      end else begin
        wr_r <= wr_r;
        wd_r <= wd_r;
      end
    end
  end

  assign IN_READY = (state_r == ST_IDLE);
  assign WR       = wr_r;
  assign WD       = wd_r;
  assign WE       = we_r;
  assign ILLEGAL  = illegal_r;

endmodule

// File: tb/tb_rtype_exec_wb.sv
// Scoreboard bench for rtype_exec_wb: the driver pushes expected writes and
// illegal pulses (with the cycle they must appear in); a monitor process
// pops and compares whenever WE or ILLEGAL is seen.
module tb_rtype_exec_wb;
  import rtype_exec_wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic        we;
  logic        illegal;

  typedef struct {
    int          cyc;
    logic [4:0]  wr;
    logic [31:0] wd;
  } exp_t;

  exp_t wq[$];
  int   iq[$];
  int   cyc;
  int   n_vec;
  int   n_bad;

  rtype_exec_wb dut (
    .CLK      (clk),
    .RST      (rst),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .INST     (inst),
    .RD1      (rd1),
    .RD2      (rd2),
    .WR       (wr),
    .WD       (wd),
    .WE       (we),
    .ILLEGAL  (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, rd, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Monitor: compares every WE / ILLEGAL pulse against the scoreboard.
  task automatic monitor();
    exp_t x;
    int   ic;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (wq.size() > 0 && cyc > wq[0].cyc) begin
          x = wq.pop_front();
          n_vec++;
          n_bad++;
          $display("FAIL missed_write: got no WE by cycle %0d, want WR=%0d WD=%h", cyc, x.wr, x.wd);
        end
        if (iq.size() > 0 && cyc > iq[0]) begin
          ic = iq.pop_front();
          n_vec++;
          n_bad++;
          $display("FAIL missed_illegal: got no ILLEGAL by cycle %0d, want pulse at %0d", cyc, ic);
        end
        if (we !== 1'b0) begin
          n_vec++;
          if (wq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got WE=%b WR=%0d WD=%h at cycle %0d, want no write", we, wr, wd, cyc);
          end else begin
            x = wq.pop_front();
            if (wr !== x.wr || wd !== x.wd || cyc != x.cyc) begin
              n_bad++;
              $display("FAIL write: got WR=%0d WD=%h cycle %0d, want WR=%0d WD=%h cycle %0d",
                       wr, wd, cyc, x.wr, x.wd, x.cyc);
            end
          end
        end
        if (illegal !== 1'b0) begin
          n_vec++;
          if (iq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_illegal: got ILLEGAL=%b at cycle %0d, want 0", illegal, cyc);
          end else begin
            ic = iq.pop_front();
            if (cyc != ic) begin
              n_bad++;
              $display("FAIL illegal_cycle: got cycle %0d, want %0d", cyc, ic);
            end
          end
        end
      end
    end
  endtask

  // Issue one instruction, queue its expectations, and check IN_READY timing.
  task automatic issue(input string nm, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input bit exp_we, input bit exp_ill,
                       input int k, input logic [31:0] exp_wd);
    int   w;
    int   e;
    int   busy;
    exp_t x;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_ready_timeout: got IN_READY=%b, want 1", nm, in_ready);
    end
    inst     = ins;
    rd1      = a;
    rd2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e        = cyc;
    in_valid = 1'b0;
    inst     = 32'hFFFF_FFFF;
    rd1      = 32'hDEAD_BEEF;
    rd2      = 32'h0000_0003;
    if (exp_ill) begin
      iq.push_back(e);
    end else if (exp_we) begin
      x.cyc = e + k;
      x.wr  = ins[11:7];
      x.wd  = exp_wd;
      wq.push_back(x);
    end
    busy = exp_ill ? 0 : k + 1;
    for (int j = 0; j < busy; j++) begin
      @(negedge clk);
      chk({nm, "_busy"}, {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    clk      = 1'b0;
    cyc      = 0;
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    inst     = 32'd0;
    rd1      = 32'd0;
    rd2      = 32'd0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_we",      {31'd0, we},       32'd0);
    chk("reset_wr",      {27'd0, wr},       32'd0);
    chk("reset_wd",      wd,                32'd0);
    chk("reset_illegal", {31'd0, illegal},  32'd0);
    chk("reset_ready",   {31'd0, in_ready}, 32'd1);

    issue("add",     mk(F7_BASE, F3_ADDSUB,  5'd3,  OP_RTYPE), 32'd5,          32'd7,          1'b1, 1'b0, 0,  32'd12);
    issue("sub",     mk(F7_ALT,  F3_ADDSUB,  5'd4,  OP_RTYPE), 32'd3,          32'd5,          1'b1, 1'b0, 0,  32'hFFFF_FFFE);
    issue("add_wrap",mk(F7_BASE, F3_ADDSUB,  5'd5,  OP_RTYPE), 32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 0,  32'd0);
    issue("slt",     mk(F7_BASE, F3_SLT,     5'd6,  OP_RTYPE), 32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 0,  32'd1);
    issue("sltu",    mk(F7_BASE, F3_SLTU,    5'd7,  OP_RTYPE), 32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 0,  32'd0);
    issue("xor",     mk(F7_BASE, F3_XOR,     5'd8,  OP_RTYPE), 32'hA5A5_A5A5,  32'h0F0F_0F0F,  1'b1, 1'b0, 0,  32'hAAAA_AAAA);
    issue("or",      mk(F7_BASE, F3_OR,      5'd10, OP_RTYPE), 32'hF0F0_0000,  32'h0000_F0F0,  1'b1, 1'b0, 0,  32'hF0F0_F0F0);
    issue("and",     mk(F7_BASE, F3_AND,     5'd11, OP_RTYPE), 32'hFF00_FF00,  32'h0FF0_0FF0,  1'b1, 1'b0, 0,  32'h0F00_0F00);
    issue("add_x0",  mk(F7_BASE, F3_ADDSUB,  5'd0,  OP_RTYPE), 32'd9,          32'd9,          1'b0, 1'b0, 0,  32'd0);
    chk("hold_wr", {27'd0, wr}, 32'd11);
    chk("hold_wd", wd,          32'h0F00_0F00);
    issue("sra4",    mk(F7_ALT,  F3_SRL_SRA, 5'd9,  OP_RTYPE), 32'h8000_0000,  32'd36,         1'b1, 1'b0, 4,  32'hF800_0000);
    issue("srl4",    mk(F7_BASE, F3_SRL_SRA, 5'd12, OP_RTYPE), 32'h8000_0000,  32'd36,         1'b1, 1'b0, 4,  32'h0800_0000);
    issue("sll0",    mk(F7_BASE, F3_SLL,     5'd13, OP_RTYPE), 32'h1234_5678,  32'h0000_0020,  1'b1, 1'b0, 0,  32'h1234_5678);
    issue("sll31",   mk(F7_BASE, F3_SLL,     5'd14, OP_RTYPE), 32'd1,          32'd31,         1'b1, 1'b0, 31, 32'h8000_0000);
    issue("sra_pos", mk(F7_ALT,  F3_SRL_SRA, 5'd16, OP_RTYPE), 32'h7FFF_FFFF,  32'd3,          1'b1, 1'b0, 3,  32'h0FFF_FFFF);
    issue("ill_op",  mk(F7_BASE, F3_ADDSUB,  5'd15, 7'b0010011), 32'd1,        32'd1,          1'b0, 1'b1, 0,  32'd0);
    issue("ill_and", mk(F7_ALT,  F3_AND,     5'd15, OP_RTYPE), 32'd1,          32'd1,          1'b0, 1'b1, 0,  32'd0);
    issue("ill_f7",  mk(7'b0000001, F3_ADDSUB, 5'd15, OP_RTYPE), 32'd1,        32'd1,          1'b0, 1'b1, 0,  32'd0);
    issue("ill_sll", mk(F7_ALT,  F3_SLL,     5'd15, OP_RTYPE), 32'd1,          32'd1,          1'b0, 1'b1, 0,  32'd0);

    // Reset in the middle of a 20-step shift: the write must be lost.
    inst     = mk(F7_BASE, F3_SLL, 5'd17, OP_RTYPE);
    rd1      = 32'd1;
    rd2      = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e        = cyc;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_we",    {31'd0, we},       32'd0);
    chk("midrst_wr",    {27'd0, wr},       32'd0);
    chk("midrst_wd",    wd,                32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_cycle", cyc - e,           32'd3);
    repeat (25) @(negedge clk);
    issue("add_after", mk(F7_BASE, F3_ADDSUB, 5'd1, OP_RTYPE), 32'd1, 32'd2, 1'b1, 1'b0, 0, 32'd3);

    repeat (5) @(negedge clk);
    chk("write_queue_drained",   wq.size(), 32'd0);
    chk("illegal_queue_drained", iq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
